// File: rtl/gray_to_rgb_pkg.sv
// Shared types and helpers for the grayscale-to-RGB888 stream expander.
// The optional pseudocolour build is selected with GRAY_TO_RGB_PSEUDOCOLOR_EN;
// see gray_to_rgb_map.sv.
package gray_to_rgb_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Counter width for a range of n positions; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_WIDTH  = 28;
  localparam int DEF_HEIGHT = 28;
  localparam int DEF_X_W    = cnt_width(DEF_WIDTH);
  localparam int DEF_Y_W    = cnt_width(DEF_HEIGHT);

  // Grey replicate, or a cold-to-hot ramp: blue->green below mid-scale,
  // green->red above it, both driven by the low seven bits doubled.
  function automatic rgb888_t map_gray(input logic [7:0] gray, input logic pseudo);
    rgb888_t    c;
    logic [7:0] ramp;
    ramp = {gray[6:0], 1'b0};
    if (!pseudo) begin
      c.r = gray;
      c.g = gray;
      c.b = gray;
    end else if (!gray[7]) begin
      c.r = 8'h00;
      c.g = ramp;
      c.b = ~ramp;
    end else begin
      c.r = ramp;
      c.g = ~ramp;
      c.b = 8'h00;
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_to_rgb_map.sv
// Combinational colour mapper between the capture stage and the output stage.
// Defining GRAY_TO_RGB_PSEUDOCOLOR_EN selects the heat-map palette; otherwise
// the grey level is replicated onto all three channels.
module gray_to_rgb_map
  import gray_to_rgb_pkg::*;
(
  input  logic [7:0] gray,
  output rgb888_t    rgb
);

`ifdef GRAY_TO_RGB_PSEUDOCOLOR_EN
  assign rgb = map_gray(gray, 1'b1);
`else
  assign rgb = map_gray(gray, 1'b0);
`endif

endmodule

// File: rtl/gray_to_rgb_stream.sv
// Streaming grayscale to RGB888 expander with raster markers.
// Two register stages: S1 captures the (optionally inverted) grey level and
// its raster position, S2 holds the mapped colour and markers for the output.
// Palette choice (GRAY_TO_RGB_PSEUDOCOLOR_EN) lives entirely in gray_to_rgb_map.
module gray_to_rgb_stream
  import gray_to_rgb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic       i_CLK,
  input  logic       i_RESET_N,
  input  logic       i_CLEAR,
  input  logic       i_INVERT,
  input  logic [7:0] i_GRAY,
  input  logic       i_VALID,
  output logic       o_READY,
  output logic [7:0] o_RED,
  output logic [7:0] o_GREEN,
  output logic [7:0] o_BLUE,
  output logic       o_VALID,
  input  logic       i_READY,
  output logic       o_SOF,
  output logic       o_EOL,
  output logic       o_EOF,
  output logic [7:0] o_FRAME_CNT
);

  localparam int XW = cnt_width(WIDTH);
  localparam int YW = cnt_width(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_p0;
  logic [YW-1:0] y_p0;

  logic [7:0]    gray_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          vld_p1;
  logic          sof_p1, eol_p1, eof_p1;

  rgb888_t       rgb_map;
  rgb888_t       rgb_p2;
  logic          sof_p2, eol_p2, eof_p2;
  logic          vld_p2;
  logic [7:0]    frame_cnt;

  logic          load_p2, load_p1, accept, out_fire;

  // S2 frees up when empty or handing off; S1 when empty or moving into S2.
  assign load_p2  = !vld_p2 || i_READY;
  assign load_p1  = !vld_p1 || load_p2;
  assign o_READY  = !i_CLEAR && load_p1;
  assign accept   = i_VALID && o_READY;
  assign out_fire = vld_p2 && i_READY;

  assign sof_p1 = (x_p1 == '0) && (y_p1 == '0);
  assign eol_p1 = (x_p1 == X_LAST);
  assign eof_p1 = eol_p1 && (y_p1 == Y_LAST);

  gray_to_rgb_map u_map (
    .gray (gray_p1),
    .rgb  (rgb_map)
  );

  // ---- stage 0: raster position of the next beat to be accepted ----
  // Raster position advances once per accepted beat, wrapping at line and frame end.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (i_CLEAR) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (accept) begin
      if (x_p0 == X_LAST) begin
        x_p0 <= '0;
        y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + 1'b1;
      end else begin
        x_p0 <= x_p0 + 1'b1;
      end
    end
  end

  // ---- stage 1: capture grey level (inversion applied) and position ----
  // Capture stage: loads whenever it can, valid tracks whether a beat came in.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      vld_p1  <= 1'b0;
      gray_p1 <= '0;
      x_p1    <= '0;
      y_p1    <= '0;
    end else if (i_CLEAR) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= accept;
      if (accept) begin
        gray_p1 <= i_INVERT ? ~i_GRAY : i_GRAY;
        x_p1    <= x_p0;
        y_p1    <= y_p0;
      end
    end
  end

  // ---- stage 2: mapped colour and markers, held until downstream takes them ----
  // Output stage: data only changes when a new beat moves in, so stalled outputs stay put.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= '0;
      sof_p2 <= 1'b0;
      eol_p2 <= 1'b0;
      eof_p2 <= 1'b0;
    end else if (i_CLEAR) begin
      vld_p2 <= 1'b0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        rgb_p2 <= rgb_map;
        sof_p2 <= sof_p1;
        eol_p2 <= eol_p1;
        eof_p2 <= eof_p1;
      end
    end
  end

  // Completed-frame count bumps when an end-of-frame beat leaves; flush leaves it alone.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      frame_cnt <= '0;
    end else if (out_fire && eof_p2) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign o_VALID     = vld_p2;
  assign o_RED       = rgb_p2.r;
  assign o_GREEN     = rgb_p2.g;
  assign o_BLUE      = rgb_p2.b;
  assign o_SOF       = sof_p2;
  assign o_EOL       = eol_p2;
  assign o_EOF       = eof_p2;
  assign o_FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_gray_to_rgb_stream.sv
// Directed bench for gray_to_rgb_stream: streaming, inversion, backpressure,
// flush, mid-stream reset and frame-counter wrap (on a small 2x2 instance).
module tb_gray_to_rgb_stream;

  localparam int W = 28;
  localparam int H = 28;

`ifdef GRAY_TO_RGB_PSEUDOCOLOR_EN
  localparam logic [23:0] INV30_RGB = 24'h9E6100;
  localparam logic [23:0] G30_RGB   = 24'h00609F;
  localparam logic [23:0] GC0_RGB   = 24'h807F00;
  localparam logic [23:0] G10_RGB   = 24'h0020DF;
`else
  localparam logic [23:0] INV30_RGB = 24'hCFCFCF;
  localparam logic [23:0] G30_RGB   = 24'h303030;
  localparam logic [23:0] GC0_RGB   = 24'hC0C0C0;
  localparam logic [23:0] G10_RGB   = 24'h101010;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, invert, vld_in, rdy_in;
  logic [7:0] gray;
  logic       rdy_out, vld_out, sof, eol, eof;
  logic [7:0] r, g, b, fcnt;

  logic       s_vld, s_rdy_out, s_vld_out, s_sof, s_eol, s_eof;
  logic [7:0] s_r, s_g, s_b, s_fcnt;

  gray_to_rgb_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_CLEAR(clear), .i_INVERT(invert),
    .i_GRAY(gray), .i_VALID(vld_in), .o_READY(rdy_out),
    .o_RED(r), .o_GREEN(g), .o_BLUE(b), .o_VALID(vld_out), .i_READY(rdy_in),
    .o_SOF(sof), .o_EOL(eol), .o_EOF(eof), .o_FRAME_CNT(fcnt)
  );

  gray_to_rgb_stream #(.WIDTH(2), .HEIGHT(2)) u_small (
    .i_CLK(clk), .i_RESET_N(rst_n), .i_CLEAR(1'b0), .i_INVERT(1'b0),
    .i_GRAY(8'h5A), .i_VALID(s_vld), .o_READY(s_rdy_out),
    .o_RED(s_r), .o_GREEN(s_g), .o_BLUE(s_b), .o_VALID(s_vld_out), .i_READY(1'b1),
    .o_SOF(s_sof), .o_EOL(s_eol), .o_EOF(s_eof), .o_FRAME_CNT(s_fcnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Expected beat: {r, g, b, sof, eol, eof}
  typedef logic [26:0] beat_t;
  beat_t       exp_q[$];
  logic [23:0] obs_q[$];
  beat_t       last_out;
  logic        last_rdy;
  int bx, by, cyc, n_out, n_acc, n_sof, n_eol, n_eof, first_acc, first_out;

  function automatic logic [23:0] expect_rgb(input logic [7:0] gv);
`ifdef GRAY_TO_RGB_PSEUDOCOLOR_EN
    logic [7:0] ramp;
    ramp = {gv[6:0], 1'b0};
    if (gv < 8'd128) return {8'h00, ramp, ~ramp};
    else             return {ramp, ~ramp, 8'h00};
`else
    return {gv, gv, gv};
`endif
  endfunction

  // One clock: sample mid-cycle, score handshakes, then step past the edge.
  task automatic cycle();
    logic  acc, dacc;
    beat_t got, e;
    logic [7:0] gv;
    #4;
    acc      = vld_in && rdy_out;
    dacc     = vld_out && rdy_in;
    last_rdy = rdy_out;
    if (dacc) begin
      got = {r, g, b, sof, eol, eof};
      n_out++;
      if (first_out < 0) first_out = cyc;
      n_sof += int'(sof);
      n_eol += int'(eol);
      n_eof += int'(eof);
      last_out = got;
      obs_q.push_back(got[26:3]);
      if (exp_q.size() == 0) begin
        check("extra_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("beat", got, e);
      end
    end
    if (acc) begin
      gv = invert ? ~gray : gray;
      exp_q.push_back({expect_rgb(gv), (bx == 0 && by == 0), (bx == W-1),
                       (bx == W-1 && by == H-1)});
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      if (bx == W-1) begin
        bx = 0;
        by = (by == H-1) ? 0 : by + 1;
      end else begin
        bx++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (clear) begin
      exp_q.delete();
      bx = 0;
      by = 0;
    end
  endtask

  task automatic drain();
    vld_in = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, o0;
    rst_n = 1'b1; clear = 1'b0; invert = 1'b0; gray = 8'h00;
    vld_in = 1'b0; rdy_in = 1'b1; s_vld = 1'b0;
    bx = 0; by = 0; cyc = 0; n_out = 0; n_acc = 0;
    n_sof = 0; n_eol = 0; n_eof = 0; first_acc = -1; first_out = -1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid", vld_out, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_marks", {sof, eol, eof}, 0);
    check("rst_fcnt", fcnt, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", rdy_out, 1);

    // Full frame, downstream always ready
    for (int i = 0; i < W*H; i++) begin
      vld_in = 1'b1;
      gray   = 8'(i);
      cycle();
    end
    drain();
    check("frame_acc", n_acc, 784);
    check("frame_out", n_out, 784);
    check("latency", first_out - first_acc, 2);
    check("sof_count", n_sof, 1);
    check("eol_count", n_eol, 28);
    check("eof_count", n_eof, 1);
    check("eof_last", last_out[0], 1);
    check("fcnt_one", fcnt, 1);

    // Inversion and palette points
    obs_q.delete();
    vld_in = 1'b1;
    invert = 1'b1; gray = 8'h30; cycle();
    invert = 1'b0; gray = 8'h30; cycle();
    gray = 8'hC0; cycle();
    drain();
    check("map_count", obs_q.size(), 3);
    check("inv_30", obs_q[0], INV30_RGB);
    check("gray_30", obs_q[1], G30_RGB);
    check("gray_c0", obs_q[2], GC0_RGB);

    // Flush with a beat offered: nothing accepted, pipeline empty
    clear = 1'b1; vld_in = 1'b1; gray = 8'h55;
    a0 = n_acc;
    cycle();
    clear = 1'b0; vld_in = 1'b0;
    check("clear_rdy", last_rdy, 0);
    check("clear_no_acc", n_acc - a0, 0);
    check("clear_empty", vld_out, 0);

    // Backpressure: two beats absorbed, output held
    rdy_in = 1'b0; vld_in = 1'b1;
    a0 = n_acc;
    for (int k = 0; k < 6; k++) begin
      gray = 8'h10 + 8'(k);
      cycle();
      if (k >= 1) check("bp_hold", {vld_out, r, g, b}, {1'b1, G10_RGB});
    end
    check("bp_accepts", n_acc - a0, 2);
    check("bp_ready_low", rdy_out, 0);
    rdy_in = 1'b1; vld_in = 1'b0;
    o0 = n_out;
    cycle();
    cycle();
    check("bp_drain", n_out - o0, 2);
    drain();

    // Flush at beat 100 of a frame
    clear = 1'b1; cycle(); clear = 1'b0;
    for (int i = 0; i < 100; i++) begin
      vld_in = 1'b1;
      gray   = 8'(i + 3);
      cycle();
    end
    clear = 1'b1; gray = 8'hAA;
    a0 = n_acc;
    cycle();
    clear = 1'b0;
    check("clr100_no_acc", n_acc - a0, 0);
    check("clr100_rdy", last_rdy, 0);
    check("clr100_empty", vld_out, 0);
    check("clr100_fcnt", fcnt, 1);
    gray = 8'h42; cycle();
    drain();
    check("clr100_sof", last_out[2], 1);

    // Reset mid-stream with output valid
    for (int i = 0; i < 10; i++) begin
      vld_in = 1'b1;
      gray   = 8'(i + 9);
      cycle();
    end
    check("pre_rst_valid", vld_out, 1);
    vld_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mrst_valid", vld_out, 0);
    check("mrst_rgb", {r, g, b}, 0);
    check("mrst_marks", {sof, eol, eof}, 0);
    check("mrst_fcnt", fcnt, 0);
    check("mrst_rdy", rdy_out, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); bx = 0; by = 0;
    vld_in = 1'b1; gray = 8'h30; cycle();
    drain();
    check("mrst_sof", last_out[2], 1);
    check("mrst_rgb_out", last_out[26:3], G30_RGB);

    // Frame counter wrap on the 2x2 instance: 255 frames, then the 256th
    s_vld = 1'b1;
    repeat (255*4) @(posedge clk);
    #1 s_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_255", s_fcnt, 255);
    s_vld = 1'b1;
    repeat (4) @(posedge clk);
    #1 s_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wrap_0", s_fcnt, 0);
    check("wrap_idle", s_vld_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
